// File: rtl/ether_arp_tx.sv
// ether_arp_tx: GMII transmitter that emits one complete ARP request or reply
// frame per accepted start, with preamble/SFD, on-the-fly CRC-32 FCS and a
// programmable inter-frame gap. All outputs are registered on clk_125.
module ether_arp_tx #(
  parameter logic [47:0] SRC_MAC    = 48'h00301BA0A48E,
  parameter logic [31:0] SRC_IP     = 32'h0A00150A,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        clk_125,
  input  logic        rst,
  input  logic        start,
  input  logic        reply,
  input  logic [31:0] tgt_ip,
  input  logic [47:0] tgt_mac,
  output logic        busy,
  output logic        done,
  output logic        phy_en,
  output logic        phy_er,
  output logic [7:0]  phy_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_FRAME,
    S_FCS,
    S_IFG
  } state_t;

  localparam int                 IFG_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0]   IFG_LAST  = IFG_W'(IFG_CYCLES - 1);
  localparam logic [31:0]        CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0]        CRC_INIT  = 32'hFFFFFFFF;
  // htype=1, ptype=0x0800, hlen=6, plen=4
  localparam logic [47:0]        ARP_FIXED = 48'h000108000604;

  // Byte-parallel reflected CRC-32 step: the loop unrolls into XOR logic.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Byte i (0 = most significant) of a 48-bit field.
  function automatic logic [7:0] byte48(input logic [47:0] v, input int i);
    return 8'(v >> (8 * (5 - i)));
  endfunction

  // Byte i (0 = most significant) of a 32-bit field.
  function automatic logic [7:0] byte32(input logic [31:0] v, input int i);
    return 8'(v >> (8 * (3 - i)));
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [31:0]      crc_q, crc_d;
  logic             reply_q, reply_d;
  logic [31:0]      tip_q, tip_d;
  logic [47:0]      tmac_q, tmac_d;
  logic             ret_q, ret_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic [7:0]       data_q, data_d;

  logic [47:0]      dst_mac;
  logic [47:0]      tha_mac;
  logic [31:0]      fcs;
  logic [7:0]       frame_byte;
  int               k;

  assign dst_mac = reply_q ? tmac_q : 48'hFFFF_FFFF_FFFF;
  assign tha_mac = reply_q ? tmac_q : 48'h0;
  assign fcs     = ~crc_q;
  assign k       = int'(cnt_q);

  // Frame content for byte index cnt_q (preamble through FCS).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    frame_byte = 8'h00;
    if (k < 7)        frame_byte = 8'h55;
    else if (k == 7)  frame_byte = 8'hD5;
    else if (k < 14)  frame_byte = byte48(dst_mac, k - 8);
    else if (k < 20)  frame_byte = byte48(SRC_MAC, k - 14);
    else if (k == 20) frame_byte = 8'h08;
    else if (k == 21) frame_byte = 8'h06;
    else if (k < 28)  frame_byte = byte48(ARP_FIXED, k - 22);
    else if (k == 28) frame_byte = 8'h00;
    else if (k == 29) frame_byte = reply_q ? 8'h02 : 8'h01;
    else if (k < 36)  frame_byte = byte48(SRC_MAC, k - 30);
    else if (k < 40)  frame_byte = byte32(SRC_IP, k - 36);
    else if (k < 46)  frame_byte = byte48(tha_mac, k - 40);
    else if (k < 50)  frame_byte = byte32(tip_q, k - 46);
    else if (k < 68)  frame_byte = 8'h00;
    else              frame_byte = 8'(fcs >> (8 * (k - 68)));
  end

  // Next-state, CRC and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ifg_d   = ifg_q;
    crc_d   = crc_q;
    reply_d = reply_q;
    tip_d   = tip_q;
    tmac_d  = tmac_q;
    ret_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    en_d    = 1'b0;
    data_d  = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        // ret_q marks the first cycle back from IFG, so done lands one
        // cycle later, in the same cycle a held start is re-accepted.
        done_d = ret_q;
        if (start) begin
          state_d = S_PREAMBLE;
          reply_d = reply;
          tip_d   = tgt_ip;
          tmac_d  = tgt_mac;
          cnt_d   = 7'd0;
          crc_d   = CRC_INIT;
        end
      end
      S_PREAMBLE: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        data_d = frame_byte;
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == 7'd7) state_d = S_FRAME;
      end
      S_FRAME: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        data_d = frame_byte;
        crc_d  = crc32_byte(crc_q, frame_byte);
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == 7'd67) state_d = S_FCS;
      end
      S_FCS: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        data_d = frame_byte;
        if (cnt_q == 7'd71) begin
          state_d = S_IFG;
          cnt_d   = 7'd0;
          ifg_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_IFG: begin
        busy_d = 1'b1;
        if (ifg_q == IFG_LAST) begin
          state_d = S_IDLE;
          ret_d   = 1'b1;
        end else begin
          ifg_d = IFG_W'(ifg_q + 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, latched request fields and output registers.
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      // NOTE: the latched request fields are reset too; they are small and
      // a known value keeps the first frame after reset deterministic.
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      ifg_q   <= '0;
      crc_q   <= CRC_INIT;
      reply_q <= 1'b0;
      tip_q   <= 32'h0;
      tmac_q  <= 48'h0;
      ret_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ifg_q   <= ifg_d;
      crc_q   <= crc_d;
      reply_q <= reply_d;
      tip_q   <= tip_d;
      tmac_q  <= tmac_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign phy_en   = en_q;
  assign phy_er   = 1'b0;
  assign phy_data = data_q;

endmodule

// File: doc/ether_arp_tx.md
# ether_arp_tx

Parametrised GMII transmitter that builds and sends complete ARP request or reply frames on demand. It fills a run-time target IP/MAC into the frame, computes the real IEEE 802.3 CRC-32 FCS on the fly, and enforces a programmable inter-frame gap. It sits in the 125 MHz GMII transmit domain and drives the PHY TX pins directly. It succeeds the fixed-content sample transmitter and adds a start/busy/done handshake and request/reply mode.

## Interface
- SRC_MAC, 48'h00301BA0A48E, local MAC, used as the Ethernet source and the ARP sender MAC
- SRC_IP, 32'h0A00150A, local IPv4 address (10.0.21.10), used as the ARP sender IP
- IFG_CYCLES, 12, idle byte-times after the last FCS byte (minimum 1)
- clk_125  in  1  GMII transmit clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to send one frame; accepted only in IDLE
- reply  in  1  latched at accept: 0 = ARP request (opcode 1), 1 = ARP reply (opcode 2)
- tgt_ip  in  32  target IP, latched at accept
- tgt_mac  in  48  target MAC, latched at accept; used only when reply=1
- busy  out  1  high from the cycle after accept through the last IFG cycle
- done  out  1  one-cycle pulse in the first cycle back in IDLE
- phy_en  out  1  GMII TX_EN
- phy_er  out  1  GMII TX_ER; constant 0
- phy_data  out  8  GMII TXD

## Operation
- All outputs are registered. Reset value of every output: phy_en=0, phy_er=0, phy_data=0x00, busy=0, done=0. Reset also forces the FSM to IDLE, clears the byte counter, and sets the CRC register to 0xFFFFFFFF.
- FSM states:
  - IDLE: start=1 latches reply/tgt_ip/tgt_mac and moves to PREAMBLE.
  - PREAMBLE: 8 bytes, then FRAME.
  - FRAME: 60 bytes, then FCS.
  - FCS: 4 bytes, then IFG.
  - IFG: IFG_CYCLES cycles, then IDLE.
- Byte index k counts from the first phy_en=1 cycle:
  - 0–6: 0x55.
  - 7: 0xD5.
  - 8–13: destination MAC. FF×6 if reply=0, else tgt_mac, MSB first.
  - 14–19: SRC_MAC.
  - 20–21: 08 06.
  - 22–27: 00 01 08 00 06 04.
  - 28–29: 00 01 (request) or 00 02 (reply).
  - 30–35: SRC_MAC.
  - 36–39: SRC_IP.
  - 40–45: target MAC field. 00×6 if request, tgt_mac if reply.
  - 46–49: tgt_ip, MSB first.
  - 50–67: 0x00 padding (18 bytes).
  - 68–71: FCS.
- CRC-32 rules:
  - Reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at the start of PREAMBLE.
  - Updated one byte per cycle, LSB-first, over bytes 8–67 only.
  - FCS = ~crc, transmitted least significant byte first.
  - A byte-parallel combinational update is required; a serial 8-cycle update is not permitted.
- Inputs are ignored outside IDLE: start while busy is dropped, not queued, and input changes after accept do not affect the frame.
- If start is held high continuously, a new frame is accepted in the cycle done pulses, giving back-to-back frames separated by exactly IFG_CYCLES+1 idle cycles.
- phy_data is 0x00 whenever phy_en=0.

## Timing
- Accept at edge N (start=1 in IDLE):
  - Edge N+1 onward: phy_en=1, phy_data=0x55, busy=1.
  - phy_en stays high for exactly 72 consecutive cycles.
- After the last FCS byte:
  - phy_en=0 for IFG_CYCLES cycles with busy=1.
  - The following cycle: busy=0, done=1.
- Latency from accept to the first preamble byte is 1 cycle; from accept to done is 72+IFG_CYCLES+1 cycles.
- Reset mid-frame: outputs go to their reset values asynchronously, with no FCS or IFG emitted. The first start after rst deasserts begins a clean frame with the CRC re-initialised.
- start coincident with rst deassertion is ignored; acceptance requires rst low at the sampling edge.

## Test plan
- Request: SRC defaults, tgt_ip=0x0A001563, reply=0, one start pulse.
  - Expect 72 phy_en cycles.
  - Bytes 8–13 = FF, 28–29 = 00 01, 46–49 = 0A 00 15 63.
  - FCS matches a software CRC-32 of bytes 8–67.
  - The reflected CRC over bytes 8–71 leaves residue 0xDEBB20E3.
- Reply: reply=1, tgt_mac=0x112233445566.
  - Expect bytes 8–13 and 40–45 = 11 22 33 44 55 66, and bytes 28–29 = 00 02.
  - FCS correct.
- Handshake: start held high.
  - Expect back-to-back frames with exactly 13 idle cycles between them (IFG_CYCLES=12).
  - done pulses once per frame; busy drops for only the done cycle.
- Ignored inputs: pulse start and change tgt_ip at byte 30.
  - Expect no second frame and an unchanged tgt_ip field.
- Reset mid-frame: assert rst at byte 40.
  - Expect phy_en=0, phy_data=0, busy=0 immediately.
  - The next start produces a frame with a correct FCS.
- Parameter sweep: IFG_CYCLES=1 and 96, non-default SRC_MAC/SRC_IP.
  - Expect the fields to follow the parameters and the idle gap to equal IFG_CYCLES+1 under continuous start.
